// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver (configurable data/parity/stop) with 3-sample majority
// voting, false-start rejection and a first-word-fall-through receive FIFO.
`timescale 1ns/1ps
module uart_rx_fifo #(
   parameter int SYS_CLK_FREQ = 50,
   parameter int BAUDRATE     = 1000000,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_A       = 4
) (
   input  logic                 CLK,
   input  logic                 RST_X,
   input  logic                 RXD,
   output logic [DATA_BITS-1:0] DATA,
   output logic                 PERR,
   output logic                 FERR,
   output logic                 VALID,
   input  logic                 READY,
   output logic [FIFO_A:0]      COUNT,
   output logic                 OVERRUN,
   input  logic                 CLEAR
);
   localparam int BIT_CNT = SYS_CLK_FREQ * 1000000 / BAUDRATE;
   localparam int HALF    = BIT_CNT / 2;
   localparam int BCW     = $clog2(BIT_CNT);
   localparam int DEPTH   = 1 << FIFO_A;
   localparam int FW      = DATA_BITS + 2;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;

   state_t               state_q, state_d;
   logic                 sync1_q, sync2_q, rxp_q;
   logic [BCW-1:0]       bc_q, bc_d;
   logic                 s0_q, s0_d, s1_q, s1_d;
   logic [3:0]           idx_q, idx_d;
   logic                 stp_q, stp_d;
   logic [DATA_BITS-1:0] sh_q, sh_d;
   logic                 perr_q, perr_d, ferr_q, ferr_d;
   logic                 push_q, push_d;
   logic [FW-1:0]        wrd_q, wrd_d;
   logic                 rx, bc_wrap, dec, maj, par_calc, ferr_now;

   assign rx       = sync2_q;
   assign bc_wrap  = (bc_q == BCW'(BIT_CNT - 1));
   assign dec      = (bc_q == BCW'(HALF + 1));
   assign maj      = (s0_q & s1_q) | (s0_q & rx) | (s1_q & rx);
   assign par_calc = (PARITY == 1) ? ~^sh_q : ^sh_q;

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         rxp_q   <= 1'b1;
         state_q <= S_IDLE;
         bc_q    <= '0;
         s0_q    <= 1'b0;
         s1_q    <= 1'b0;
         idx_q   <= '0;
         stp_q   <= 1'b0;
         sh_q    <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         push_q  <= 1'b0;
         wrd_q   <= '0;
      end else begin
         sync1_q <= RXD;
         sync2_q <= sync1_q;
         rxp_q   <= rx;
         state_q <= state_d;
         bc_q    <= bc_d;
         s0_q    <= s0_d;
         s1_q    <= s1_d;
         idx_q   <= idx_d;
         stp_q   <= stp_d;
         sh_q    <= sh_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         push_q  <= push_d;
         wrd_q   <= wrd_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      bc_d     = bc_wrap ? '0 : bc_q + 1'b1;
      s0_d     = s0_q;
      s1_d     = s1_q;
      idx_d    = idx_q;
      stp_d    = stp_q;
      sh_d     = sh_q;
      perr_d   = perr_q;
      ferr_d   = ferr_q;
      push_d   = 1'b0;
      wrd_d    = wrd_q;
      ferr_now = ferr_q | ~maj;
      if (bc_q == BCW'(HALF - 1)) s0_d = rx;
      if (bc_q == BCW'(HALF))     s1_d = rx;
      case (state_q)
         S_IDLE: begin
            bc_d = '0;
            if (rxp_q && !rx) begin
               state_d = S_START;
               idx_d   = '0;
               stp_d   = 1'b0;
               perr_d  = 1'b0;
               ferr_d  = 1'b0;
            end
         end
         S_START: begin
            if (dec && maj) begin
               state_d = S_IDLE;
               bc_d    = '0;
            end else if (bc_wrap) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (dec) sh_d = {maj, sh_q[DATA_BITS-1:1]};
            if (bc_wrap) begin
               if (idx_q == 4'(DATA_BITS - 1)) state_d = (PARITY != 0) ? S_PAR : S_STOP;
               else                            idx_d   = idx_q + 1'b1;
            end
         end
         S_PAR: begin
            if (dec)     perr_d  = (maj != par_calc);
            if (bc_wrap) state_d = S_STOP;
         end
         S_STOP: begin
            if (dec) begin
               ferr_d = ferr_now;
               // Leave at the last stop decision, not at wrap, so a back-to-back start edge is seen.
               if (stp_q == 1'(STOP_BITS - 1)) begin
                  push_d  = 1'b1;
                  wrd_d   = {sh_q, perr_q, ferr_now};
                  state_d = ferr_now ? S_BRK : S_IDLE;
                  bc_d    = '0;
               end
            end
            if (bc_wrap) stp_d = 1'b1;
         end
         S_BRK: begin
            bc_d = '0;
            if (rx) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   logic [FW-1:0]     mem_q [DEPTH];
   logic [FIFO_A-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [FIFO_A:0]   cnt_q, cnt_d;
   logic              ovr_q, ovr_d;
   logic              pop, acc;

   assign VALID   = (cnt_q != '0);
   assign COUNT   = cnt_q;
   assign OVERRUN = ovr_q;
   assign pop     = VALID & READY;
   // A full FIFO still accepts when the head is leaving in the same cycle.
   assign acc     = push_q & ((cnt_q != (FIFO_A+1)'(DEPTH)) | pop);
   assign {DATA, PERR, FERR} = VALID ? mem_q[rp_q] : '0;

   always_comb begin
      wp_d  = acc ? wp_q + 1'b1 : wp_q;
      rp_d  = pop ? rp_q + 1'b1 : rp_q;
      cnt_d = cnt_q;
      if (acc && !pop)      cnt_d = cnt_q + 1'b1;
      else if (!acc && pop) cnt_d = cnt_q - 1'b1;
      ovr_d = ovr_q;
      if (push_q && !acc) ovr_d = 1'b1;
      else if (CLEAR)     ovr_d = 1'b0;
   end

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
         ovr_q <= 1'b0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
         ovr_q <= ovr_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (acc) mem_q[wp_q] <= wrd_q;
   end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised successor to the fixed 8N1 UART receiver used by the loader path.
- Adds configurable data bits, parity and stop bits, 3-sample majority voting, false-start rejection, and per-word parity/framing error flags.
- Received words are buffered in a first-word-fall-through FIFO with a valid/ready dequeue port, plus a sticky overrun flag.
- Sits between the board UART pin and loader/Coram control logic, so consumers no longer need to keep up with single-cycle receive pulses.

Parameters:
- SYS_CLK_FREQ, 50, system clock in MHz.
- BAUDRATE, 1000000, line rate in bit/s. BIT_CNT = SYS_CLK_FREQ*1000000/BAUDRATE, integer-truncated, must be >= 8. HALF = BIT_CNT/2.
- DATA_BITS, 8, data bits per frame, 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits checked, 1 or 2.
- FIFO_A, 4, log2 of FIFO depth (depth 16).

Ports:
- CLK  in  1  system clock.
- RST_X  in  1  asynchronous active-low reset.
- RXD  in  1  serial input; idles high; asynchronous to CLK.
- DATA  out  DATA_BITS  head-of-FIFO word, LSB = first bit received.
- PERR  out  1  parity error flag of head word.
- FERR  out  1  framing error flag of head word.
- VALID  out  1  FIFO non-empty; DATA/PERR/FERR valid.
- READY  in  1  consumer accepts head word when VALID&&READY.
- COUNT  out  FIFO_A+1  FIFO occupancy.
- OVERRUN  out  1  sticky: a completed frame was dropped because the FIFO was full.
- CLEAR  in  1  synchronous clear of OVERRUN.

Behaviour:
- Reset (RST_X low, async): state IDLE, all counters 0, FIFO empty, VALID=0, COUNT=0, OVERRUN=0, DATA/PERR/FERR=0. The two-flop RXD synchroniser presets to 1. Reset mid-frame discards the partial frame.
- All sampling uses the synchronised RXD, which lags the pin by 2 cycles.
- Bit timing:
  - Bit counter bc counts 0..BIT_CNT-1.
  - Samples are taken at bc = HALF-1, HALF and HALF+1.
  - The bit value is the majority of the three samples, decided at bc = HALF+1.
- States:
  - IDLE: on a synchronised 1->0 transition, set bc=0 and go to START.
  - START: at the decision point, majority 1 means false start; return to IDLE with nothing stored. Otherwise go to DATA at bc wrap.
  - DATA: shift in DATA_BITS bits LSB first, one per bit period. After the last bit, go to PAR if PARITY != 0, else to STOP.
  - PAR: computed = XOR of data bits (XNOR for odd). PERR_int = majority value != computed.
  - STOP: check STOP_BITS stop periods. Any stop majority of 0 sets FERR_int. At the decision point of the last stop bit, push the word and go to IDLE if FERR_int = 0, or to BRKWAIT if FERR_int = 1. This is not at bc wrap, so the next start edge is caught early.
  - BRKWAIT: stay until synchronised RXD = 1, then go to IDLE. This prevents a low line from retriggering.
- Push:
  - {DATA, PERR, FERR} are written in the cycle after the last stop decision.
  - Frames with errors are still stored, with their flags set.
  - A push is accepted if COUNT < depth, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped and OVERRUN is set. If set and CLEAR coincide, set wins.
- FIFO:
  - First-word-fall-through. VALID rises the cycle after a push into an empty FIFO.
  - Pop on VALID&&READY. The next word appears the following cycle.
  - READY while VALID=0 is ignored.
  - Pointers wrap modulo depth. COUNT updates +1, -1, or 0 for simultaneous push and pop.
- Latency, start edge at pin to VALID, with DATA_BITS=8, PARITY=0, STOP_BITS=1: 2 + 9*BIT_CNT + HALF + 1 + 1 + 1 cycles.

Test Plan:
Defaults used unless stated: BIT_CNT=50, HALF=25.
1. Send 0xA5 as 8N1 at exact baud -> VALID rises; DATA=0xA5, PERR=0, FERR=0, COUNT=1. With READY=1 for one cycle -> VALID=0, COUNT=0.
2. Low glitch of 10 cycles on RXD in IDLE -> false start; nothing stored; COUNT stays 0.
3. With PARITY=2, send 0x3C with parity bit 1 -> PERR=1, DATA=0x3C. Resend with parity bit 0 -> PERR=0.
4. Send 0x55 with stop bit 0, then hold RXD low 300 cycles, then send 0x12 -> exactly two words: 0x55 with FERR=1, then 0x12 with FERR=0.
5. With READY=0, send 17 frames 0x00..0x10 -> COUNT=16, OVERRUN=1. Draining yields 0x00..0x0F in order. Assert CLEAR -> OVERRUN=0.
6. Assert RST_X low mid-DATA of frame 0x77 and release -> VALID=0, COUNT=0. The next frame 0x81 is received correctly. Also, single-cycle 1-flips at sample HALF of each bit do not alter DATA.
